keypad_mov_scan: RTL and testbench
==================================

Name: keypad_mov_scan

Overview:
- Upstream stage of the character-motion block: scans a 4x4 active-low matrix keypad and produces the debounced direction vector mov[3:0] = {up, down, left, right}.
- mov is a level per key: held high while the key is pressed. The motion block samples it on its own slow divided clock.
- Scanning, synchronisation and debounce all run in the sys_clk domain.

Parameters:
- SCAN_DIV, 50000: sys_clk cycles each column is driven before its rows are sampled; legal range >= 2.
- DEBOUNCE_CNT, 8: consecutive disagreeing scan frames needed to change a mov bit; legal range 1..15.

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- key_row  in  4  keypad rows, active-low, pulled up externally, asynchronous to sys_clk.
- key_col  out  4  keypad column drive, active-low, exactly one column low at a time.
- mov  out  4  debounced {up, down, left, right}; 1 = pressed.
- frame_tick  out  1  one-cycle pulse when column 3 has been sampled.

Behaviour:
- Reset (async, rst=1):
  - key_col=4'b1110, col_idx=0, div_cnt=0.
  - mov=4'b0000, frame_tick=0.
  - All debounce counters, raw bits and synchroniser flops cleared; synchroniser flops reset to 4'b1111.
  - Deassertion is taken on the next sys_clk edge; there is no partial-frame carry-over.
- Synchroniser: key_row passes through 2 flops (row_s) before any use.
- Column scan:
  - div_cnt counts 0..SCAN_DIV-1.
  - When div_cnt==SCAN_DIV-1: sample ~row_s into raw[col_idx], set div_cnt=0, advance col_idx (3 wraps to 0), drive key_col=~(4'b0001<<next col_idx).
  - frame_tick=1 on the cycle column 3 is sampled.
  - One frame = 4*SCAN_DIV cycles.
- Key map, from the raw frame (row r, column c):
  - up = (r0, c1), key "2".
  - down = (r2, c1), key "8".
  - left = (r1, c0), key "4".
  - right = (r1, c2), key "6".
  - All other keys are ignored.
- Debounce, per mov bit i, updated only on frame_tick:
  - If raw_i == mov[i]: cnt_i = 0.
  - Else cnt_i += 1. When cnt_i reaches DEBOUNCE_CNT, mov[i] toggles and cnt_i = 0.
  - Both press and release are debounced.
  - Counter width is 4 bits and saturates safely because it is cleared at DEBOUNCE_CNT.
- Latency:
  - A stable press or release changes mov after DEBOUNCE_CNT frame_ticks, plus up to one frame of sampling alignment and 2 synchroniser cycles.
  - mov updates on the cycle after frame_tick.
- Bits are independent. Any combination may be high at once, including up+down or left+right, unless the optional feature is compiled in.
- A bounce (raw agrees with mov again) before DEBOUNCE_CNT frames clears cnt_i; the count restarts from 0.
- Row activity on an undriven column has no effect.
- Reset mid-frame: all state cleared immediately; mov drops to 0 asynchronously.

Optional Feature:
- Macro: KEYPAD_OPPOSE_BLOCK_EN.
- Defined:
  - After debounce, if up and down are both high, mov[3] and mov[2] are both driven 0. Likewise for left and right on mov[1] and mov[0].
  - Masking is combinational on the registered debounced bits; the debounce state itself is untouched.
  - Releasing one key of a masked pair restores the other key's output in the same cycle its debounced release takes effect.
- Undefined: no masking; mov equals the debounced bits.

Test Plan:
- Reset and scan, SCAN_DIV=4, DEBOUNCE_CNT=3, rst held then released:
  - mov=0000 and key_col=1110 during reset.
  - key_col then steps 1110->1101->1011->0111->1110, each column for 4 cycles.
  - frame_tick pulses every 16 cycles.
- Press left: key_row[1]=0 whenever key_col==1110, held.
  - mov[1] rises after the 3rd frame_tick that sees the press, and not before cycle 48.
  - On release, mov[1] falls 3 frames later.
  - Other bits stay 0.
- Glitch: right key pressed for exactly 1 frame, then released -> mov stays 0000; internal count returns to 0.
- Bounce: up pressed for 2 frames, released 1 frame, pressed 2 frames -> mov[3] stays 0. Held thereafter, it rises on the 3rd consecutive pressed frame.
- Opposing keys, left+right held:
  - Without the macro: mov=0011.
  - With KEYPAD_OPPOSE_BLOCK_EN: mov=0000. Releasing left gives mov=0001 once the release is debounced.
- Async reset mid-press: with mov=1000, rst pulsed for 1 ns between edges -> mov=0000 immediately, key_col=1110, scan restarts at column 0.

Source files
------------

// File: rtl/keypad_mov_scan.sv
// keypad_mov_scan: scans a 4x4 active-low matrix keypad and produces the
// debounced direction vector mov = {up, down, left, right} for the motion block.
//
// Ports:
//   sys_clk     system clock
//   rst         asynchronous active-high reset
//   key_row     keypad rows, active-low, asynchronous to sys_clk
//   key_col     column drive, active-low, one-hot-low
//   mov         debounced {up, down, left, right}, 1 = pressed
//   frame_tick  one-cycle pulse once column 3 has been sampled
//
// Parameters:
//   SCAN_DIV      cycles each column is driven before its rows are sampled (>= 2)
//   DEBOUNCE_CNT  consecutive disagreeing frames needed to flip a mov bit (1..15)
//
// Optional build macro KEYPAD_OPPOSE_BLOCK_EN: when defined, opposing directions
// held together (up+down, left+right) are both masked to 0 on the output.

// Per-direction debounce lane: counts frames whose raw value disagrees with the
// current debounced value and flips once DEBOUNCE_CNT are seen back to back.
module keypad_mov_deb #(
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic upd,
    input  logic raw_bit,
    output logic deb
);
    logic [3:0] cnt;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
            deb <= 1'b0;
        end else if (upd) begin
            if (raw_bit == deb) begin
                cnt <= 4'd0;
            end else if (cnt == 4'(DEBOUNCE_CNT - 1)) begin
                // Clearing here keeps the 4-bit count from ever wrapping.
                deb <= ~deb;
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
            end
        end
    end
endmodule

module keypad_mov_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] mov,
    output logic       frame_tick
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    // Two-flop synchroniser; idle (unpressed) rows read as 1.
    logic [1:0][3:0] row_s;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            row_s <= {2{4'b1111}};
        end else begin
            row_s <= {row_s[0], key_row};
        end
    end

    // raw[c][r] = key at row r, column c was seen pressed in the latest scan.
    logic [DW-1:0]   div_cnt;
    logic [1:0]      col_idx;
    logic [3:0][3:0] raw;
    logic [1:0]      col_nxt;

    assign col_nxt = col_idx + 2'd1;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= '0;
            col_idx    <= 2'd0;
            key_col    <= 4'b1110;
            raw        <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (div_cnt == DIV_LAST) begin
                raw[col_idx] <= ~row_s[1];
                div_cnt      <= '0;
                col_idx      <= col_nxt;
                key_col      <= ~(4'b0001 << col_nxt);
                frame_tick   <= (col_idx == 2'd3);
            end else begin
                div_cnt <= div_cnt + DW'(1);
            end
        end
    end

    // Only keys 2/8/4/6 drive motion; the rest of the frame is deliberately dropped.
    logic unused_raw;
    assign unused_raw = ^raw;

    logic [3:0] raw_dir;
    assign raw_dir = {raw[1][0], raw[1][2], raw[0][1], raw[2][1]};

    logic [3:0] deb;

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_deb
            keypad_mov_deb #(.DEBOUNCE_CNT(DEBOUNCE_CNT)) u_deb (
                .sys_clk (sys_clk),
                .rst     (rst),
                .upd     (frame_tick),
                .raw_bit (raw_dir[i]),
                .deb     (deb[i])
            );
        end
    endgenerate

`ifdef KEYPAD_OPPOSE_BLOCK_EN
    // Masking sits after the registers so the debounce state keeps tracking both keys.
    assign mov = {deb[3:2] & {2{~(&deb[3:2])}},
                  deb[1:0] & {2{~(&deb[1:0])}}};
`else
    assign mov = deb;
`endif
endmodule

// File: tb/tb_keypad_mov_scan.sv
// Bench for keypad_mov_scan: keypad matrix model driving key_row from key_col,
// frame-level reference model for mov, per-cycle compare plus directed checks.
module tb_keypad_mov_scan;
    localparam int SD = 4;
    localparam int DB = 3;
    localparam int FR = 4 * SD;

    localparam logic [15:0] K_U = 16'h0002;  // row 0, col 1
    localparam logic [15:0] K_D = 16'h0200;  // row 2, col 1
    localparam logic [15:0] K_L = 16'h0010;  // row 1, col 0
    localparam logic [15:0] K_R = 16'h0040;  // row 1, col 2

    logic       sys_clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] mov;
    logic       frame_tick;

    always #5 sys_clk = ~sys_clk;

    keypad_mov_scan #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DB)) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .key_row    (key_row),
        .key_col    (key_col),
        .mov        (mov),
        .frame_tick (frame_tick)
    );

    // Pressed-key matrix, bit r*4+c; a pressed key shorts its row to a driven column.
    logic [15:0] pressed = 16'h0;

    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !key_col[c]) key_row[r] = 1'b0;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] dir_of(input logic [15:0] m);
        return {m[1], m[9], m[4], m[6]};
    endfunction

    function automatic logic [3:0] msk(input logic [3:0] d);
        logic [3:0] o;
        o = d;
`ifdef KEYPAD_OPPOSE_BLOCK_EN
        if (o[3] && o[2]) o[3:2] = 2'b00;
        if (o[1] && o[0]) o[1:0] = 2'b00;
`endif
        return o;
    endfunction

    // Reference model: e = sys_clk edges since reset release. Frame f covers
    // edges f*FR+1 .. (f+1)*FR and its debounce result appears after edge (f+1)*FR+1.
    int          e = 0;
    logic [3:0]  m_deb = 4'b0;
    int          m_run [4];
    logic [15:0] frame_mat [512];
    int          fcnt = 0;

    initial for (int i = 0; i < 4; i++) m_run[i] = 0;

    always @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            e     <= 0;
            m_deb <= 4'b0;
            for (int i = 0; i < 4; i++) m_run[i] <= 0;
        end else begin
            e <= e + 1;
            if (e >= FR && e % FR == 0) begin
                for (int i = 0; i < 4; i++) begin
                    // run = how many frames in a row the key disagreed with mov
                    if (dir_of(frame_mat[e/FR - 1])[i] == m_deb[i]) begin
                        m_run[i] <= 0;
                    end else if (m_run[i] + 1 >= DB) begin
                        m_deb[i] <= ~m_deb[i];
                        m_run[i] <= 0;
                    end else begin
                        m_run[i] <= m_run[i] + 1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge sys_clk) begin
        logic [3:0] exp_col;
        if (!rst) begin
            exp_col = ~(4'b0001 << ((e / SD) % 4));
            chk("key_col", key_col, exp_col);
            chk("frame_tick", {3'b0, frame_tick}, {3'b0, (e > 0 && e % FR == 0)});
            chk("mov", mov, msk(m_deb));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic set_frame(input logic [15:0] m);
        pressed = m;
        frame_mat[fcnt] = m;
        fcnt++;
    endtask

    task automatic frame(input logic [15:0] m);
        set_frame(m);
        cyc(FR);
    endtask

    logic [15:0] cur;
    logic [3:0]  exp_lr;

    initial begin
        // Reset held
        cyc(3);
        chk("rst_mov", mov, 4'b0000);
        chk("rst_col", key_col, 4'b1110);
        chk("rst_tick", {3'b0, frame_tick}, 4'b0000);
        rst = 1'b0;

        // Idle frame: column step and first frame_tick
        set_frame(16'h0);
        cyc(SD);
        chk("col1_lit", key_col, 4'b1101);
        cyc(FR - SD);
        chk("tick_lit", {3'b0, frame_tick}, 4'b0001);

        // Left press: rises one cycle after the 3rd pressed frame completes
        frame(K_L); frame(K_L); frame(K_L);
        chk("left_early", mov, 4'b0000);
        set_frame(K_L); cyc(1);
        chk("left_rise", mov, 4'b0010);
        cyc(FR - 1);
        frame(16'h0); frame(16'h0); frame(16'h0);
        chk("left_hold", mov, 4'b0010);
        set_frame(16'h0); cyc(1);
        chk("left_fall", mov, 4'b0000);
        cyc(FR - 1);

        // One-frame glitch on right
        frame(K_R); frame(16'h0); frame(16'h0); frame(16'h0);
        chk("glitch", mov, 4'b0000);

        // Bounce on up, then held
        frame(K_U); frame(K_U); frame(16'h0); frame(K_U); frame(K_U);
        set_frame(K_U); cyc(1);
        chk("bounce", mov, 4'b0000);
        cyc(FR - 1);
        set_frame(K_U); cyc(1);
        chk("up_rise", mov, 4'b1000);
        cyc(FR - 1);

        // Opposing left+right while up releases
        frame(K_L | K_R); frame(K_L | K_R); frame(K_L | K_R);
        set_frame(K_L | K_R); cyc(1);
`ifdef KEYPAD_OPPOSE_BLOCK_EN
        exp_lr = 4'b0000;
`else
        exp_lr = 4'b0011;
`endif
        chk("oppose", mov, exp_lr);
        cyc(FR - 1);
        frame(K_R); frame(K_R); frame(K_R);
        set_frame(K_R); cyc(1);
        chk("oppose_rel", mov, 4'b0001);
        cyc(FR - 1);

        // Random frames; the four direction keys persist, the rest is noise
        cur = pressed;
        for (int f = 0; f < 200; f++) begin
            cur = (cur & (K_U | K_D | K_L | K_R)) |
                  (16'($urandom) & ~(K_U | K_D | K_L | K_R));
            if ($urandom_range(0, 3) == 0) cur ^= K_U;
            if ($urandom_range(0, 3) == 0) cur ^= K_D;
            if ($urandom_range(0, 3) == 0) cur ^= K_L;
            if ($urandom_range(0, 3) == 0) cur ^= K_R;
            frame(cur);
        end

        // Async reset mid-frame with up held
        frame(K_U); frame(K_U); frame(K_U); frame(K_U);
        set_frame(K_U); cyc(5);
        chk("pre_rst", mov, 4'b1000);
        #1 rst = 1'b1;
        #1;
        chk("async_mov", mov, 4'b0000);
        chk("async_col", key_col, 4'b1110);
        rst = 1'b0;
        fcnt = 0;
        frame(K_U); frame(K_U); frame(K_U);
        set_frame(K_U); cyc(1);
        chk("post_rst_up", mov, 4'b1000);
        cyc(FR - 1);
        frame(16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
